// File: rtl/pc_pkg.sv
// Shared encodings and defaults for the PC / next-PC unit.
package pc_pkg;

  localparam logic [1:0] BR_BEQ  = 2'b00;
  localparam logic [1:0] BR_BNE  = 2'b01;
  localparam logic [1:0] BR_BLEZ = 2'b10;
  localparam logic [1:0] BR_BGTZ = 2'b11;

  localparam int unsigned DEF_INSTR_BYTES = 4;
  localparam logic [31:0] DEF_RESET_PC    = 32'h0000_0000;

  typedef enum logic {StIdle, StPending} pend_state_e;

  function automatic logic branch_cond(input logic [1:0] br_type, input logic zero_flag,
                                       input logic neg_flag);
    logic c;
    unique case (br_type)
      BR_BEQ:  c = zero_flag;
      BR_BNE:  c = !zero_flag;
      BR_BLEZ: c = zero_flag | neg_flag;
      default: c = !zero_flag & !neg_flag;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/pc_redirect_unit_if.sv
// Request/response bundle between control/ALU flags and the PC unit.
interface pc_redirect_unit_if #(
  parameter int unsigned PC_W    = 32,
  parameter int unsigned IMM_W   = 16,
  parameter int unsigned JADDR_W = 26,
  parameter int unsigned CNT_W   = 16
);
  logic               stall;
  logic               branch_en;
  logic [1:0]         branch_type;
  logic               zero_flag;
  logic               neg_flag;
  logic [IMM_W-1:0]   imm;
  logic               jump_en;
  logic [JADDR_W-1:0] jump_addr;
  logic               jr_en;
  logic [PC_W-1:0]    jr_addr;
  logic [PC_W-1:0]    pc;
  logic [PC_W-1:0]    pc_plus;
  logic [PC_W-1:0]    imm_ext;
  logic               taken;
  logic               flush;
  logic [CNT_W-1:0]   redirect_cnt;

  modport master (
    output stall, branch_en, branch_type, zero_flag, neg_flag, imm,
           jump_en, jump_addr, jr_en, jr_addr,
    input  pc, pc_plus, imm_ext, taken, flush, redirect_cnt
  );

  modport slave (
    input  stall, branch_en, branch_type, zero_flag, neg_flag, imm,
           jump_en, jump_addr, jr_en, jr_addr,
    output pc, pc_plus, imm_ext, taken, flush, redirect_cnt
  );
endinterface

// File: rtl/branch_target_gen.sv
// Branch offset sign extension, target adder and condition evaluation.
module branch_target_gen
  import pc_pkg::*;
#(
  parameter int unsigned PC_W         = 32,
  parameter int unsigned IMM_W        = 16,
  parameter int unsigned OFFSET_SHIFT = 2
) (
  input  logic [PC_W-1:0]  pc_plus,
  input  logic [IMM_W-1:0] imm,
  input  logic [1:0]       branch_type,
  input  logic             zero_flag,
  input  logic             neg_flag,
  output logic [PC_W-1:0]  imm_ext,
  output logic [PC_W-1:0]  br_target,
  output logic             cond
);

  assign imm_ext   = {{(PC_W-IMM_W){imm[IMM_W-1]}}, imm};
  // Adder wraps modulo 2^PC_W by construction.
  assign br_target = pc_plus + (imm_ext << OFFSET_SHIFT);
  assign cond      = branch_cond(branch_type, zero_flag, neg_flag);

endmodule

// File: rtl/pc_redirect_unit.sv
// Program counter with prioritised redirect, stall-time redirect buffering and flush pulse.
module pc_redirect_unit
  import pc_pkg::*;
#(
  parameter int unsigned     PC_W         = 32,
  parameter int unsigned     IMM_W        = 16,
  parameter int unsigned     JADDR_W      = 26,
  parameter int unsigned     OFFSET_SHIFT = 2,
  parameter int unsigned     INSTR_BYTES  = DEF_INSTR_BYTES,
  parameter logic [PC_W-1:0] RESET_PC     = PC_W'(DEF_RESET_PC),
  parameter int unsigned     CNT_W        = 16
) (
  input logic               clk,
  input logic               rst,
  pc_redirect_unit_if.slave bus
);

  logic [PC_W-1:0]  pc_q, pend_target_q;
  logic [PC_W-1:0]  pc_plus, imm_ext, br_target, j_target, req_target;
  pend_state_e      state_q;
  logic             flush_q;
  logic [CNT_W-1:0] cnt_q;
  logic             cond, taken;

  assign pc_plus = pc_q + PC_W'(INSTR_BYTES);

  branch_target_gen #(
    .PC_W         (PC_W),
    .IMM_W        (IMM_W),
    .OFFSET_SHIFT (OFFSET_SHIFT)
  ) u_branch_target_gen (
    .pc_plus     (pc_plus),
    .imm         (bus.imm),
    .branch_type (bus.branch_type),
    .zero_flag   (bus.zero_flag),
    .neg_flag    (bus.neg_flag),
    .imm_ext     (imm_ext),
    .br_target   (br_target),
    .cond        (cond)
  );

  assign j_target = {pc_plus[PC_W-1:JADDR_W+2], bus.jump_addr, 2'b00};
  assign taken    = bus.jr_en | bus.jump_en | (bus.branch_en & cond);

  always_comb begin
    req_target = br_target;
    if (bus.jr_en) begin
      req_target = bus.jr_addr;
    end else if (bus.jump_en) begin
      req_target = j_target;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      pend_target_q <= '0;
      state_q       <= StIdle;
      flush_q       <= 1'b0;
      cnt_q         <= '0;
    end else if (!bus.stall) begin
      if (state_q == StPending || taken) begin
        // A buffered redirect wins: the request seen now is on the wrong path.
        pc_q    <= (state_q == StPending) ? pend_target_q : req_target;
        state_q <= StIdle;
        flush_q <= 1'b1;
        if (cnt_q != {CNT_W{1'b1}}) begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end else begin
        pc_q    <= pc_plus;
        flush_q <= 1'b0;
      end
    end else begin
      flush_q <= 1'b0;
      if (taken) begin
        pend_target_q <= req_target;
        state_q       <= StPending;
      end
    end
  end

  assign bus.pc           = pc_q;
  assign bus.pc_plus      = pc_plus;
  assign bus.imm_ext      = imm_ext;
  assign bus.taken        = taken;
  assign bus.flush        = flush_q;
  assign bus.redirect_cnt = cnt_q;

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Table, directed and random checks of pc_redirect_unit against a behavioural model.
module tb_pc_redirect_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pc_redirect_unit_if #(.CNT_W(16)) bus ();
  pc_redirect_unit_if #(.CNT_W(2))  bus2 ();

  pc_redirect_unit #(.CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  pc_redirect_unit #(.CNT_W(2)) dut_sat (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  typedef struct {
    logic        stall;
    logic        br_en;
    logic [1:0]  br_type;
    logic        zero;
    logic        neg;
    logic [15:0] imm;
    logic        jmp;
    logic [25:0] jaddr;
    logic        jr;
    logic [31:0] jr_addr;
    logic [31:0] exp_pc;
    logic        exp_flush;
    logic [15:0] exp_cnt;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model state
  logic [31:0] m_pc;
  logic        m_flush;
  int unsigned m_cnt;
  logic [31:0] pend_q[$];

  function automatic vec_t mk(logic stall, logic br_en, logic [1:0] br_type, logic zero,
                              logic neg, logic [15:0] imm, logic jmp, logic [25:0] jaddr,
                              logic jr, logic [31:0] jr_addr, logic [31:0] exp_pc,
                              logic exp_flush, logic [15:0] exp_cnt);
    vec_t v;
    v.stall = stall; v.br_en = br_en; v.br_type = br_type; v.zero = zero; v.neg = neg;
    v.imm = imm; v.jmp = jmp; v.jaddr = jaddr; v.jr = jr; v.jr_addr = jr_addr;
    v.exp_pc = exp_pc; v.exp_flush = exp_flush; v.exp_cnt = exp_cnt;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.stall = v.stall; bus.branch_en = v.br_en; bus.branch_type = v.br_type;
    bus.zero_flag = v.zero; bus.neg_flag = v.neg; bus.imm = v.imm;
    bus.jump_en = v.jmp; bus.jump_addr = v.jaddr; bus.jr_en = v.jr; bus.jr_addr = v.jr_addr;
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_flush = 1'b0; m_cnt = 0; pend_q.delete();
  endtask

  // Drive one cycle, check combinational outputs, clock, check registered outputs.
  task automatic apply(input vec_t v, input bit use_exp);
    logic [31:0] plus, ext, tgt;
    logic        c, tk;
    drive(v);
    #1;
    plus = m_pc + 32'd4;
    ext  = 32'($signed(v.imm));
    case (v.br_type)
      2'd0:    c = v.zero;
      2'd1:    c = !v.zero;
      2'd2:    c = v.zero || v.neg;
      default: c = !v.zero && !v.neg;
    endcase
    tk = v.jr || v.jmp || (v.br_en && c);
    if (v.jr)       tgt = v.jr_addr;
    else if (v.jmp) tgt = (plus & 32'hF000_0000) | (32'(v.jaddr) * 4);
    else            tgt = plus + ext * 4;
    chk("taken", {31'd0, bus.taken}, {31'd0, tk});
    chk("pc_plus", bus.pc_plus, plus);
    chk("imm_ext", bus.imm_ext, ext);
    @(posedge clk);
    if (!v.stall) begin
      if (pend_q.size() != 0) begin
        m_pc = pend_q.pop_front(); m_flush = 1'b1;
        if (m_cnt < 65535) m_cnt++;
      end else if (tk) begin
        m_pc = tgt; m_flush = 1'b1;
        if (m_cnt < 65535) m_cnt++;
      end else begin
        m_pc = plus; m_flush = 1'b0;
      end
    end else begin
      m_flush = 1'b0;
      if (tk) begin
        pend_q.delete();
        pend_q.push_back(tgt);
      end
    end
    #1;
    chk("model_pc", bus.pc, m_pc);
    chk("model_flush", {31'd0, bus.flush}, {31'd0, m_flush});
    chk("model_cnt", {16'd0, bus.redirect_cnt}, m_cnt);
    if (use_exp) begin
      chk("exp_pc", bus.pc, v.exp_pc);
      chk("exp_flush", {31'd0, bus.flush}, {31'd0, v.exp_flush});
      chk("exp_cnt", {16'd0, bus.redirect_cnt}, {16'd0, v.exp_cnt});
    end
  endtask

  vec_t idle;
  vec_t tbl[18];
  vec_t stl[5];
  logic [1:0] sat_exp[5];

  initial begin
    idle = mk(0, 0, 0, 0, 0, 16'h0, 0, 26'h0, 0, 32'h0, 32'h0, 0, 16'h0);
    drive(idle);
    bus2.stall = 0; bus2.branch_en = 0; bus2.branch_type = 0; bus2.zero_flag = 0;
    bus2.neg_flag = 0; bus2.imm = 0; bus2.jump_en = 0; bus2.jump_addr = 0;
    bus2.jr_en = 0; bus2.jr_addr = 0;
    model_reset();

    // Reset, then free-run to 0x10
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      vec_t v;
      v = idle; v.exp_pc = 32'(4 * i);
      apply(v, 1'b1);
    end

    // Asynchronous reset between edges
    #2;
    rst = 1'b1;
    #1;
    chk("rst_pc", bus.pc, 32'h0);
    chk("rst_cnt", {16'd0, bus.redirect_cnt}, 32'h0);
    chk("rst_flush", {31'd0, bus.flush}, 32'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    begin
      vec_t v;
      v = idle; v.exp_pc = 32'h4; apply(v, 1'b1);
      v = idle; v.exp_pc = 32'h8; apply(v, 1'b1);
    end

    //        stall br bt  z  n  imm       j  jaddr     jr jr_addr        pc        f cnt
    tbl[0]  = mk(0, 0, 0, 0, 0, 16'h0000, 0, 26'h00, 1, 32'h20,       32'h20,       1, 1);
    tbl[1]  = mk(0, 1, 0, 1, 0, 16'h0003, 0, 26'h00, 0, 32'h0,        32'h30,       1, 2);
    tbl[2]  = mk(0, 0, 0, 0, 0, 16'h0000, 0, 26'h00, 1, 32'h20,       32'h20,       1, 3);
    tbl[3]  = mk(0, 1, 0, 0, 0, 16'h0003, 0, 26'h00, 0, 32'h0,        32'h24,       0, 3);
    tbl[4]  = mk(0, 0, 0, 0, 0, 16'h0000, 0, 26'h00, 1, 32'h100,      32'h100,      1, 4);
    tbl[5]  = mk(0, 1, 1, 0, 0, 16'hFFFE, 0, 26'h00, 0, 32'h0,        32'hFC,       1, 5);
    tbl[6]  = mk(0, 1, 2, 0, 1, 16'h0001, 0, 26'h00, 0, 32'h0,        32'h104,      1, 6);
    tbl[7]  = mk(0, 1, 3, 0, 0, 16'h0002, 0, 26'h00, 0, 32'h0,        32'h110,      1, 7);
    tbl[8]  = mk(0, 1, 3, 1, 0, 16'h0002, 0, 26'h00, 0, 32'h0,        32'h114,      0, 7);
    tbl[9]  = mk(0, 1, 0, 1, 0, 16'h0002, 1, 26'h40, 1, 32'h400,      32'h400,      1, 8);
    tbl[10] = mk(0, 0, 0, 0, 0, 16'h0000, 0, 26'h00, 1, 32'h1000,     32'h1000,     1, 9);
    tbl[11] = mk(0, 1, 0, 1, 0, 16'h0002, 1, 26'h40, 0, 32'h0,        32'h100,      1, 10);
    tbl[12] = mk(0, 0, 0, 0, 0, 16'h0000, 0, 26'h00, 0, 32'h0,        32'h104,      0, 10);
    tbl[13] = mk(0, 1, 2, 0, 0, 16'h0005, 0, 26'h00, 0, 32'h0,        32'h108,      0, 10);
    tbl[14] = mk(0, 1, 1, 1, 0, 16'h0005, 0, 26'h00, 0, 32'h0,        32'h10C,      0, 10);
    tbl[15] = mk(0, 0, 0, 0, 0, 16'h0000, 0, 26'h00, 1, 32'hFFFFFFFC, 32'hFFFFFFFC, 1, 11);
    tbl[16] = mk(0, 0, 0, 0, 0, 16'h0000, 0, 26'h00, 0, 32'h0,        32'h0,        0, 11);
    tbl[17] = mk(0, 1, 2, 1, 0, 16'h0010, 0, 26'h00, 0, 32'h0,        32'h44,       1, 12);
    foreach (tbl[i]) apply(tbl[i], 1'b1);

    // Stall: branch to 0x80, then jump to 0x200 overwrites it; release ignores jr
    stl[0] = mk(1, 1, 0, 1, 0, 16'h000E, 0, 26'h00, 0, 32'h0,   32'h44,  0, 12);
    stl[1] = mk(1, 0, 0, 0, 0, 16'h0000, 1, 26'h80, 0, 32'h0,   32'h44,  0, 12);
    stl[2] = mk(1, 0, 0, 0, 0, 16'h0000, 0, 26'h00, 0, 32'h0,   32'h44,  0, 12);
    stl[3] = mk(0, 0, 0, 0, 0, 16'h0000, 0, 26'h00, 1, 32'h999, 32'h200, 1, 13);
    stl[4] = mk(0, 0, 0, 0, 0, 16'h0000, 0, 26'h00, 0, 32'h0,   32'h204, 0, 13);
    foreach (stl[i]) apply(stl[i], 1'b1);

    // Random stimulus against the model
    for (int i = 0; i < 400; i++) begin
      vec_t v;
      v = idle;
      v.stall   = ($urandom_range(3) == 0);
      v.br_en   = ($urandom_range(9) < 4);
      v.br_type = 2'($urandom_range(3));
      v.zero    = 1'($urandom);
      v.neg     = 1'($urandom);
      v.imm     = 16'($urandom);
      v.jmp     = ($urandom_range(9) == 0);
      v.jaddr   = 26'($urandom);
      v.jr      = ($urandom_range(9) == 0);
      v.jr_addr = $urandom;
      apply(v, 1'b0);
    end
    drive(idle);

    // Saturating counter on the 2-bit instance
    sat_exp[0] = 2'd1; sat_exp[1] = 2'd2; sat_exp[2] = 2'd3; sat_exp[3] = 2'd3;
    sat_exp[4] = 2'd3;
    for (int i = 0; i < 5; i++) begin
      bus2.jump_en   = 1'b1;
      bus2.jump_addr = 26'($urandom);
      @(posedge clk);
      #1;
      chk("sat_cnt", {30'd0, bus2.redirect_cnt}, {30'd0, sat_exp[i]});
      chk("sat_flush", {31'd0, bus2.flush}, 32'h1);
    end
    bus2.jump_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
